// File: rtl/imem_loader.sv
// Byte-addressed instruction memory with a sequential byte-stream loader and a 10-byte fetch window.
// Optional macro IMEM_CHECKSUM_EN adds load_csum, a 16-bit wrapping sum of the bytes of the current load.
module imem_loader #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic [ADDR_W:0]   load_count,
  output logic              cpu_run,
  output logic              load_fault,
  input  logic [63:0]       f_pc,
  output logic [79:0]       f_instr,
  output logic              imem_error
`ifdef IMEM_CHECKSUM_EN
  , output logic [15:0]     load_csum
`endif
);

  localparam int IDX_W = $clog2(MEM_BYTES);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(MEM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic              accept;
  logic              clear;
  logic [7:0]        mem [MEM_BYTES];
  logic [64:0]       fetch_end;
  logic [ADDR_W:0]   lane_addr;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    clear     = 1'b0;
    unique case (state)
      IDLE: begin
        if (ld_start) begin
          state_nxt = LOAD;
          clear     = 1'b1;
        end
      end
      LOAD: begin
        if (ld_valid) begin
          accept = 1'b1;
          // A last beat landing exactly on the final slot is a legal full load.
          if (ld_last)                 state_nxt = RUN;
          else if (wr_ptr == LAST_PTR) state_nxt = FAULT;
        end
      end
      RUN, FAULT: begin
        if (ld_start) begin
          state_nxt = LOAD;
          clear     = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ld_ready   = (state == LOAD);
  assign cpu_run    = (state == RUN);
  assign load_fault = (state == FAULT);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      load_count <= '0;
    end else if (clear) begin
      wr_ptr     <= '0;
      load_count <= '0;
    end else if (accept) begin
      wr_ptr     <= wr_ptr + 1'b1;
      load_count <= load_count + 1'b1;
    end
  end

  // The array is deliberately not reset; load_count masks anything stale.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[IDX_W-1:0]] <= ld_data;
  end

`ifdef IMEM_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || clear) load_csum <= '0;
    else if (accept)  load_csum <= load_csum + {8'h00, ld_data};
  end
`endif

  assign fetch_end  = {1'b0, f_pc} + 65'd10;
  assign imem_error = (state != RUN) || (fetch_end > 65'(MEM_BYTES));

  always_comb begin
    f_instr   = '0;
    lane_addr = '0;
    if (!imem_error) begin
      for (int i = 0; i < 10; i++) begin
        lane_addr = f_pc[ADDR_W:0] + (ADDR_W+1)'(i);
        if (lane_addr < load_count) f_instr[8*i +: 8] = mem[lane_addr[IDX_W-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: load, fetch window bounds, overflow, gaps, reset mid-load.
module tb_imem_loader;

  localparam int MB = 1024;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst, ld_start, ld_valid, ld_data_last;
  logic          ld_ready, cpu_run, load_fault, imem_error;
  logic [7:0]    ld_data;
  logic [AW:0]   load_count;
  logic [63:0]   f_pc;
  logic [79:0]   f_instr;
`ifdef IMEM_CHECKSUM_EN
  logic [15:0]   load_csum;
`endif

  int errors = 0;
  int checks = 0;

  imem_loader #(.MEM_BYTES(MB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_data_last), .load_count(load_count), .cpu_run(cpu_run),
    .load_fault(load_fault), .f_pc(f_pc), .f_instr(f_instr), .imem_error(imem_error)
`ifdef IMEM_CHECKSUM_EN
    , .load_csum(load_csum)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_data_last = last;
    step();
    ld_valid = 1'b0; ld_data_last = 1'b0;
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_data_last = 1'b0; f_pc = '0;
    step(); step();
    chk("rst_ready", ld_ready, 0);
    chk("rst_run", cpu_run, 0);
    chk("rst_fault", load_fault, 0);
    chk("rst_count", load_count, 0);
    chk("rst_err", imem_error, 1);
    rst = 1'b0;
    step();

    // Basic 3-byte load
    pulse_start();
    chk("load_ready", ld_ready, 1);
    chk("load_run", cpu_run, 0);
    beat(8'h30, 1'b0);
    beat(8'hF0, 1'b0);
    chk("load_mid_run", cpu_run, 0);
    beat(8'h10, 1'b1);
    chk("basic_run", cpu_run, 1);
    chk("basic_ready", ld_ready, 0);
    chk("basic_count", load_count, 3);
    f_pc = 64'd0; #1;
    chk("basic_instr", f_instr, 80'h10F030);
    chk("basic_err", imem_error, 0);
    f_pc = 64'd1; #1;
    chk("halt_lanes", f_instr, 80'h10F0);

    // Window bounds
    f_pc = 64'(MB - 10); #1;
    chk("edge_ok_err", imem_error, 0);
    chk("edge_ok_instr", f_instr, 0);
    f_pc = 64'(MB - 9); #1;
    chk("edge_bad_err", imem_error, 1);
    chk("edge_bad_instr", f_instr, 0);
    f_pc = 64'hFFFF_FFFF_FFFF_FFFA; #1;
    chk("wrap_err", imem_error, 1);
    chk("wrap_instr", f_instr, 0);
    f_pc = 64'd0;

    // Overflow: MEM_BYTES+1 bytes, no last
    pulse_start();
    chk("reload_run", cpu_run, 0);
    chk("reload_count", load_count, 0);
    for (int i = 0; i < MB; i++) begin
      if (i == MB - 1) chk("ovf_pre_fault", load_fault, 0);
      beat(8'(i), 1'b0);
    end
    chk("ovf_fault", load_fault, 1);
    chk("ovf_run", cpu_run, 0);
    chk("ovf_ready", ld_ready, 0);
    chk("ovf_count", load_count, MB);
    beat(8'hEE, 1'b0);
    chk("ovf_extra_count", load_count, MB);
    chk("ovf_hold", load_fault, 1);
    pulse_start();
    chk("clr_fault", load_fault, 0);
    chk("clr_count", load_count, 0);
    chk("clr_ready", ld_ready, 1);

    // Gapped valid with ld_start ignored in LOAD
    beat(8'hA1, 1'b0);
    ld_start = 1'b1; ld_data = 8'h55; ld_data_last = 1'b1;
    step();
    ld_start = 1'b0; ld_data_last = 1'b0;
    chk("gap_count", load_count, 1);
    chk("gap_ready", ld_ready, 1);
    beat(8'hB2, 1'b0);
    beat(8'hC3, 1'b1);
    chk("gap_run", cpu_run, 1);
    chk("gap_final_count", load_count, 3);
    f_pc = 64'd0; #1;
    chk("gap_instr", f_instr, 80'hC3B2A1);

    // Reset mid-load
    pulse_start();
    beat(8'hDE, 1'b0);
    beat(8'hAD, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_run", cpu_run, 0);
    chk("mrst_count", load_count, 0);
    chk("mrst_ready", ld_ready, 0);
    chk("mrst_err", imem_error, 1);
    chk("mrst_instr", f_instr, 0);
    step();
    pulse_start();
    beat(8'h77, 1'b1);
    #1;
    chk("stale_masked", f_instr, 80'h77);
    chk("stale_count", load_count, 1);

`ifdef IMEM_CHECKSUM_EN
    pulse_start();
    chk("csum_clear", load_csum, 0);
    beat(8'hFF, 1'b0);
    beat(8'hFF, 1'b0);
    beat(8'h02, 1'b1);
    chk("csum_sum", load_csum, 16'h0200);
    step();
    chk("csum_hold", load_csum, 16'h0200);
    pulse_start();
    beat(8'h05, 1'b1);
    chk("csum_reload", load_csum, 16'h0005);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
